// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment counter tile.
// Segment patterns are gfedcba, active-high.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int UI_RUN   = 0;
    localparam int UI_DIR   = 1;
    localparam int UI_CLR   = 2;
    localparam int UI_FAST  = 3;
    localparam int UIO_WRAP = 7;

endpackage

// File: rtl/tt_um_seven_segment_counter_mux_if.sv
// TT harness pin bundle; master is the harness side, slave is the tile side.
interface tt_um_seven_segment_counter_mux_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to gfedcba decoder; codes above 9 blank the digit.
module seg7_decode
    import seven_seg_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) seg = SEG_LUT[bcd];
    end

endmodule

// File: rtl/tt_um_seven_segment_counter_mux.sv
// Multi-digit BCD up/down counter with tick prescaler and time-multiplexed
// seven-segment drive for a TT tile.
module tt_um_seven_segment_counter_mux
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV     = 10_000_000,
    parameter int NUM_DIGITS   = 4,
    parameter int MUX_DIV      = 1000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         P_SLOW_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]         P_FAST_LAST = PW'(TICK_DIV / 10 - 1);
    localparam logic [MW-1:0]         M_LAST      = MW'(MUX_DIV - 1);
    localparam logic [IW-1:0]         I_LAST      = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE      = 1;
    localparam logic [NUM_DIGITS-1:0] EN_MASK     = {NUM_DIGITS{COMMON_ANODE}};
    localparam logic [7:0]            UO_MASK     = {8{COMMON_ANODE}};

    logic run, dir, clr, fast;
    assign run  = ui_in[UI_RUN];
    assign dir  = ui_in[UI_DIR];
    assign clr  = ui_in[UI_CLR];
    assign fast = ui_in[UI_FAST];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};

    // Prescaler: ">=" rather than "==" so enabling fast mid-period ticks next cycle.
    logic [PW-1:0] presc;
    logic [PW-1:0] period_last;
    logic          tick;

    assign period_last = fast ? P_FAST_LAST : P_SLOW_LAST;
    assign tick        = run & ~clr & (presc >= period_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr || tick) begin
            presc <= '0;
        end else if (run) begin
            presc <= presc + 1'b1;
        end
    end

    // BCD chain: carry[k] means digit k steps this cycle in the direction of dir.
    logic [NUM_DIGITS:0]     carry;
    logic [4*NUM_DIGITS-1:0] digits_flat;

    assign carry[0] = tick;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_t digit_q;
        bcd_t digit_nxt;
        logic at_limit;

        assign at_limit     = dir ? (digit_q == 4'd0) : (digit_q == 4'd9);
        assign carry[k+1]   = carry[k] & at_limit;
        assign digits_flat[4*k +: 4] = digit_q;

        always_comb begin
            digit_nxt = digit_q;
            if (carry[k]) begin
                if (at_limit)  digit_nxt = dir ? 4'd9 : 4'd0;
                else if (dir)  digit_nxt = digit_q - 4'd1;
                else           digit_nxt = digit_q + 4'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   digit_q <= '0;
            else if (clr) digit_q <= '0;
            else          digit_q <= digit_nxt;
        end
    end

    logic [MW-1:0] mux_t;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_t <= '0;
            idx   <= '0;
        end else if (mux_t == M_LAST) begin
            mux_t <= '0;
            idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
        end else begin
            mux_t <= mux_t + 1'b1;
        end
    end

    bcd_t       digit_sel;
    logic [6:0] seg_sel;

    assign digit_sel = digits_flat[4*int'(idx) +: 4];

    seg7_decode u_decode (
        .bcd (digit_sel),
        .seg (seg_sel)
    );

    // Output register holds the active-high form; polarity is a constant XOR after it.
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= '0;
            dp_q   <= 1'b0;
            en_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            seg_q  <= seg_sel;
            dp_q   <= (idx == '0) & ~run;
            en_q   <= EN_ONE << idx;
            wrap_q <= carry[NUM_DIGITS];
        end
    end

    assign uo_out = {dp_q, seg_q} ^ UO_MASK;

    always_comb begin
        uio_out                   = '0;
        uio_out[NUM_DIGITS-1:0]   = en_q ^ EN_MASK;
        uio_out[UIO_WRAP]         = wrap_q;
    end

    always_comb begin
        uio_oe                    = '0;
        uio_oe[NUM_DIGITS-1:0]    = '1;
        uio_oe[UIO_WRAP]          = 1'b1;
    end

endmodule
